// File: rtl/tile_pkg.sv
// Shared types and sizes for the tile-flip memory game.
// Holds the board geometry, the controller state enum and a tile lookup.
package tile_pkg;

    localparam int NUM_TILES = 16;
    localparam int TILE_W    = 3;
    localparam int NUM_PAIRS = 8;
    localparam int IDX_W     = 4;
    localparam int VALS_W    = NUM_TILES * TILE_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_FIRST,
        WAIT_SECOND,
        COMPARE,
        SHOW,
        DONE
    } state_t;

    // Value of tile i from the packed value vector.
    function automatic logic [TILE_W-1:0] tile_val(
        input logic [VALS_W-1:0] v,
        input logic [IDX_W-1:0]  i
    );
        return v[i*TILE_W +: TILE_W];
    endfunction

endpackage

// File: rtl/show_timer.sv
// Loadable down-counter timing how long a mismatched pair stays visible.
// Ports: clk, reset (async, active-low), load (preset to SHOW_CYCLES-1), done (count is 0).
module show_timer #(
    parameter int SHOW_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(SHOW_CYCLES - 1);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/tile_match_ctrl.sv
// Memory-game controller: latches tile values, reveals pairs, scores matches.
// Ports: clk, reset (async low), shuffled_vals, start, sel_valid/sel_idx in;
//        face_up, matched, move_count, pair_count, busy, game_over out.
module tile_match_ctrl
    import tile_pkg::*;
#(
    parameter int SHOW_CYCLES = 50000000,
    parameter int MOVE_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [VALS_W-1:0]    shuffled_vals,
    input  logic                 start,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_idx,
    output logic [NUM_TILES-1:0] face_up,
    output logic [NUM_TILES-1:0] matched,
    output logic [MOVE_W-1:0]    move_count,
    output logic [3:0]           pair_count,
    output logic                 busy,
    output logic                 game_over
);

    state_t             state;
    state_t             nxt;
    logic [VALS_W-1:0]  vals;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   second_idx;

    logic acc_first;
    logic acc_second;
    logic vals_eq;
    logic cmp_hit;
    logic show_end;
    logic t_load;
    logic t_done;

    show_timer #(
        .SHOW_CYCLES(SHOW_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (t_load),
        .done  (t_done)
    );

    // start overrides every other action in the same cycle.
    always_comb begin
        vals_eq    = tile_val(vals, first_idx) == tile_val(vals, second_idx);
        acc_first  = (state == WAIT_FIRST) && sel_valid && !start
                     && !face_up[sel_idx];
        acc_second = (state == WAIT_SECOND) && sel_valid && !start
                     && !face_up[sel_idx];
        cmp_hit    = (state == COMPARE) && !start && vals_eq;
        t_load     = (state == COMPARE) && !start && !vals_eq;
        show_end   = (state == SHOW) && !start && t_done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (start) begin
            nxt = LOAD;
        end else begin
            unique case (state)
                IDLE:        nxt = IDLE;
                LOAD:        nxt = WAIT_FIRST;
                WAIT_FIRST:  if (acc_first) nxt = WAIT_SECOND;
                WAIT_SECOND: if (acc_second) nxt = COMPARE;
                COMPARE: begin
                    if (!vals_eq) begin
                        nxt = SHOW;
                    end else if (pair_count == 4'(NUM_PAIRS - 1)) begin
                        nxt = DONE;
                    end else begin
                        nxt = WAIT_FIRST;
                    end
                end
                SHOW:        if (t_done) nxt = WAIT_FIRST;
                DONE:        nxt = DONE;
                default:     nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        game_over = 1'b0;
        unique case (1'b1)
            (state == COMPARE),
            (state == SHOW): busy      = 1'b1;
            (state == DONE): game_over = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vals       <= '0;
            first_idx  <= '0;
            second_idx <= '0;
            face_up    <= '0;
            matched    <= '0;
            move_count <= '0;
            pair_count <= '0;
        end else begin
            if (state == LOAD) begin
                vals       <= shuffled_vals;
                face_up    <= '0;
                matched    <= '0;
                move_count <= '0;
                pair_count <= '0;
            end
            if (acc_first) begin
                first_idx        <= sel_idx;
                face_up[sel_idx] <= 1'b1;
            end
            if (acc_second) begin
                second_idx       <= sel_idx;
                face_up[sel_idx] <= 1'b1;
                if (move_count != '1) begin
                    move_count <= move_count + MOVE_W'(1);
                end
            end
            if (cmp_hit) begin
                matched[first_idx]  <= 1'b1;
                matched[second_idx] <= 1'b1;
                pair_count          <= pair_count + 4'd1;
            end
            if (show_end) begin
                face_up[first_idx]  <= 1'b0;
                face_up[second_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tile_match_ctrl.sv
// Self-checking bench for tile_match_ctrl with a rule-level game model.
// Directed scenarios followed by randomized games.
module tb_tile_match_ctrl;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [47:0] shuffled_vals = '0;
    logic        start = 1'b0;
    logic        sel_valid = 1'b0;
    logic [3:0]  sel_idx = '0;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic [7:0]  move_count;
    logic [3:0]  pair_count;
    logic        busy;
    logic        game_over;

    always #5 clk = ~clk;

    tile_match_ctrl #(
        .SHOW_CYCLES(S),
        .MOVE_W(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .shuffled_vals (shuffled_vals),
        .start         (start),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .face_up       (face_up),
        .matched       (matched),
        .move_count    (move_count),
        .pair_count    (pair_count),
        .busy          (busy),
        .game_over     (game_over)
    );

    int ncmp = 0;
    int nfail = 0;

    // Game model: which tiles are shown / paired, score, pending first pick.
    int          rv [16];
    logic [15:0] rface;
    logic [15:0] rmatch;
    int          rmoves;
    int          rpairs;
    bit          rover;
    bit          ractive;
    int          rfirst;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".face_up"}, 32'(face_up), 32'(rface));
        chk({tag, ".matched"}, 32'(matched), 32'(rmatch));
        chk({tag, ".moves"}, 32'(move_count), (rmoves > 255) ? 255 : rmoves);
        chk({tag, ".pairs"}, 32'(pair_count), rpairs);
        chk({tag, ".over"}, 32'(game_over), 32'(rover));
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    // mode 0: i mod 8, mode 1: shuffled exact pairs, mode 2: anything
    task automatic set_vals(input int mode);
        int t;
        int j;
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       rv[i] = i % 8;
                1:       rv[i] = i % 8;
                default: rv[i] = int'($urandom_range(0, 7));
            endcase
        end
        if (mode == 1) begin
            for (int i = 15; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = rv[i];
                rv[i] = rv[j];
                rv[j] = t;
            end
        end
        for (int i = 0; i < 16; i++) begin
            shuffled_vals[i*3 +: 3] = 3'(rv[i]);
        end
    endtask

    task automatic m_reset();
        rface = '0;
        rmatch = '0;
        rmoves = 0;
        rpairs = 0;
        rover = 1'b0;
        ractive = 1'b0;
        rfirst = -1;
    endtask

    task automatic m_start();
        m_reset();
        ractive = 1'b1;
    endtask

    // Apply one player pick to the model; reports whether it completed a move.
    task automatic m_sel(input int i, output bit second, output bit eq);
        second = 1'b0;
        eq = 1'b0;
        if (ractive && !rover && !rface[i]) begin
            rface[i] = 1'b1;
            if (rfirst < 0) begin
                rfirst = i;
            end else begin
                second = 1'b1;
                rmoves++;
                if (rv[rfirst] == rv[i]) begin
                    eq = 1'b1;
                    rmatch[rfirst] = 1'b1;
                    rmatch[i] = 1'b1;
                    rpairs++;
                    if (rpairs == 8) rover = 1'b1;
                end else begin
                    rface[rfirst] = 1'b0;
                    rface[i] = 1'b0;
                end
                rfirst = -1;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        m_start();
    endtask

    // inj: -1 none, -2 random picks while busy, >=0 that tile mid-show
    task automatic do_sel(input int i, input int inj);
        int          a;
        int          bc;
        bit          second;
        bit          eq;
        logic [15:0] showm;
        a = rfirst;
        sel_valid = 1'b1;
        sel_idx = 4'(i);
        tick();
        sel_valid = 1'b0;
        m_sel(i, second, eq);
        showm = rface;
        if (second) showm = showm | (16'(1) << a) | (16'(1) << i);
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin
            chk("show_face", 32'(face_up), 32'(showm));
            if (inj == -2 && $urandom_range(0, 2) == 0) begin
                sel_valid = 1'b1;
                sel_idx = 4'($urandom_range(0, 15));
            end else if (inj >= 0 && bc == 2) begin
                sel_valid = 1'b1;
                sel_idx = 4'(inj);
            end
            tick();
            sel_valid = 1'b0;
            bc++;
        end
        chk("busy_len", 32'(bc), !second ? 0 : (eq ? 1 : 1 + S));
        chk_all("sel");
    endtask

    initial begin
        m_reset();
        set_vals(0);

        repeat (3) tick();
        chk_all("reset");
        reset = 1'b1;
        tick();
        chk_all("idle");
        do_sel(5, -1);

        do_start();
        chk_all("load");
        do_sel(0, -1);
        do_sel(8, -1);
        chk("match.face", 32'(face_up), 32'h0101);
        chk("match.matched", 32'(matched), 32'h0101);
        chk("match.pairs", 32'(pair_count), 1);
        chk("match.moves", 32'(move_count), 1);

        do_start();
        do_sel(1, -1);
        do_sel(2, 3);
        chk("mis.face", 32'(face_up), 32'h0000);
        chk("mis.moves", 32'(move_count), 1);

        do_start();
        do_sel(4, -1);
        do_sel(4, -1);
        do_sel(12, -1);
        chk("ill.moves", 32'(move_count), 1);
        chk("ill.matched", 32'(matched), 32'h1010);

        do_start();
        for (int i = 0; i < 8; i++) begin
            do_sel(i, -1);
            do_sel(i + 8, -1);
        end
        chk("full.over", 32'(game_over), 1);
        chk("full.matched", 32'(matched), 32'hffff);
        chk("full.moves", 32'(move_count), 8);
        chk("full.pairs", 32'(pair_count), 8);
        do_sel(3, -1);
        do_start();
        chk_all("restart");

        do_sel(1, -1);
        sel_valid = 1'b1;
        sel_idx = 4'd2;
        tick();
        sel_valid = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk_all("async_rst");
        tick();
        reset = 1'b1;
        tick();
        chk_all("post_rst");

        do_start();
        do_sel(3, -1);
        start = 1'b1;
        sel_valid = 1'b1;
        sel_idx = 4'd5;
        tick();
        start = 1'b0;
        sel_valid = 1'b0;
        tick();
        m_start();
        chk("abort.face", 32'(face_up), 32'h0000);
        chk_all("abort");

        for (int g = 0; g < 6; g++) begin
            set_vals((g % 2 == 0) ? 1 : 2);
            do_start();
            for (int k = 0; k < 120; k++) begin
                if (rover || $urandom_range(0, 60) == 0) begin
                    do_start();
                end
                do_sel(int'($urandom_range(0, 15)), -2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/tile_match_ctrl.md
Name: tile_match_ctrl

Overview:
- Game controller that sits directly downstream of the tile shuffler in the tile-flip memory game.
- Latches the 48-bit packed tile-value vector when a game starts, then accepts player tile selections.
- Reveals two tiles per move and compares their values.
- Keeps matched pairs face-up; flips mismatched pairs back down after a timed show period.
- Drives face-up/matched masks, move and pair counters, and a game-over flag to the display logic.

Parameters:
- SHOW_CYCLES, 50000000, number of clk cycles a mismatched pair stays visible (0.5 s at 100 MHz); legal range is at least 1.
- MOVE_W, 8, width of the move counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- shuffled_vals  input  48  packed tile values; tile i value = bits [i*3 +: 3].
- start  input  1  single-cycle pulse; latches shuffled_vals and begins a new game.
- sel_valid  input  1  single-cycle pulse; the player selected tile sel_idx.
- sel_idx  input  4  index of the selected tile, 0..15.
- face_up  output  16  bit i = 1 when tile i is currently shown (includes matched tiles).
- matched  output  16  bit i = 1 when tile i belongs to a found pair.
- move_count  output  MOVE_W  completed moves (second selections accepted); saturates at all-ones.
- pair_count  output  4  pairs found, 0..8.
- busy  output  1  1 in COMPARE and SHOW; selections are ignored while busy.
- game_over  output  1  1 in DONE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - face_up, matched, move_count, pair_count, busy and game_over all = 0.
  - Latched value array cleared to 0; first/second index registers = 0.
- IDLE: sel_valid ignored. On start -> LOAD.
- LOAD (1 cycle):
  - Copy shuffled_vals into the internal 16x3 array.
  - Clear face_up, matched, move_count and pair_count.
  - -> WAIT_FIRST.
- WAIT_FIRST:
  - A sel_valid with tile sel_idx not face-up is accepted: record first index, set face_up[sel_idx] on the next edge, -> WAIT_SECOND.
  - A sel_valid on a tile that is already face-up or matched is ignored; no state or counter change.
- WAIT_SECOND:
  - A sel_valid on a tile not face-up is accepted: record second index, set its face_up bit, increment move_count (saturating), -> COMPARE.
  - Reselecting the first tile, or any face-up tile, is ignored.
- COMPARE (1 cycle, busy = 1):
  - If the two latched values are equal: set both matched bits, pair_count + 1.
  - Then -> DONE if the new pair_count == 8, else -> WAIT_FIRST.
  - If the values are unequal: load the show timer with SHOW_CYCLES-1, -> SHOW.
- SHOW (busy = 1):
  - Timer decrements each cycle.
  - At 0: clear both face_up bits on that edge, -> WAIT_FIRST.
  - Total visible time after COMPARE = SHOW_CYCLES cycles.
- DONE: game_over = 1; all tiles face-up and matched; sel_valid ignored. start -> LOAD.
- Latency from accepted second select:
  - Match: matched bits visible 2 edges after the select.
  - Mismatch: face-down visible 2 + SHOW_CYCLES edges after the select.
- start in any non-IDLE state: abort the current game -> LOAD (restart). start has priority over a same-cycle sel_valid.
- sel_valid during LOAD, COMPARE or SHOW is dropped, not queued.
- Equality is on 3-bit values only; indices play no part. Duplicate values beyond two copies are not checked.
- Reset asserted mid-game (including mid-SHOW) returns everything to the reset values immediately.

Decomposition:
- Shared package tile_pkg:
  - NUM_TILES = 16, TILE_W = 3, NUM_PAIRS = 8, IDX_W = 4.
  - State enum: IDLE, LOAD, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, DONE.
- Sub-module show_timer:
  - Loadable down-counter, width $clog2(SHOW_CYCLES).
  - Ports: load, done pulse; same clk/reset.

Test Plan:
All scenarios use SHOW_CYCLES = 4 and tile i value = i mod 8.
- Reset then idle: hold reset = 0 for 3 cycles, release, no start -> all outputs 0. sel_valid with sel_idx = 5 has no effect.
- Match: start, then select 0, then select 8 -> face_up = 0x0101, matched = 0x0101, pair_count = 1, move_count = 1, busy high for exactly 1 cycle.
- Mismatch: select 1, then select 2 -> face_up = 0x0006 for 4 cycles after COMPARE, then 0x0000. move_count = 1, busy high for 5 cycles. A select of 3 during SHOW is ignored.
- Illegal selects: select 4, select 4 again, then select 12 -> second 4 ignored, move_count = 1, match recorded on 4/12.
- Full game: 8 matching pairs (i, i+8) -> pair_count = 8, matched = 0xFFFF, game_over = 1, move_count = 8. A further sel_valid changes nothing. start -> all masks and counters cleared.
- Abort: pulse reset = 0 mid-SHOW -> all outputs 0 asynchronously. A separate start pulse during WAIT_SECOND -> LOAD, face_up = 0 on the next edge.
